flash_prog_ctrl: RTL and testbench
==================================

Name: flash_prog_ctrl

Overview:
- In-system programming sequencer for the cartridge's 512k parallel flash (29F040-class, JEDEC command set).
- The Atari drives it through a CCTL register window at $D5D0..$D5D7.
- When busy, it takes ownership of the flash bus from the read-only cartridge mapper.
- It issues unlock/command write cycles, then polls DQ7/DQ5 until the operation completes or times out.

Parameters:
- UNLOCK_A1, 19'h00555, first unlock address.
- UNLOCK_A2, 19'h002AA, second unlock address.
- TMO_W, 27, timeout counter width.
- PROG_TMO, 27'd1024, byte-program timeout in phi2 cycles.
- ERASE_TMO, 27'd113000000, sector/chip erase timeout in phi2 cycles.

Ports:
- phi2  in  1  system clock; all state changes on posedge.
- reset_n  in  1  synchronous active-low reset.
- cctl_n  in  1  CCTL select ($D5xx).
- r_w  in  1  Atari read/write.
- cart_a  in  8  Atari address low byte.
- cart_d_in  in  8  Atari write data.
- cart_d_out  out  8  register read data.
- cart_d_oe  out  1  drive cart_d (register read in window).
- map_rom_a  in  19  mapper read address.
- map_ce_n  in  1  mapper chip enable.
- map_oe_n  in  1  mapper output enable.
- rom_a  out  19  flash address.
- rom_d_in  in  8  flash data in.
- rom_d_out  out  8  flash write data.
- rom_d_oe  out  1  drive rom_d.
- rom_ce_n  out  1  flash chip enable.
- rom_oe_n  out  1  flash output enable.
- rom_we_n  out  1  flash write enable.
- busy  out  1  controller owns flash; mapper must suppress cart_d.

Behaviour:
- Register window is hit = ~cctl_n & cart_a[7:3]==5'b11010. Writes are sampled at posedge phi2 when hit & ~r_w.
  - $D5D0/$D5D1/$D5D2[2:0]: ADDR[7:0]/[15:8]/[18:16].
  - $D5D3: DATA.
  - $D5D5: KEY. Writing 8'h5A arms; any other value disarms.
  - $D5D4 write: CMD.
    - 8'h01 program byte.
    - 8'h02 sector erase (sector = ADDR[18:16]).
    - 8'h03 chip erase.
    - 8'hF0 abort.
  - $D5D4 read: STATUS = {busy, tmo_err, vfy_err, 4'b0, armed}. Other offsets read 8'h00.
- cart_d_oe = hit & r_w & phi2.
- CMD 01/02/03 is accepted only when armed & ~busy. Acceptance clears tmo_err, vfy_err and armed. Otherwise the write is ignored.
- Register writes to ADDR/DATA while busy are ignored.
- Reset values:
  - state IDLE; ADDR/DATA 0; armed 0; tmo_err 0; vfy_err 0; busy 0.
  - rom_we_n 1; rom_d_oe 0; counters 0.
- Bus mux:
  - IDLE: rom_a/rom_ce_n/rom_oe_n = map_*; rom_we_n 1.
  - Otherwise the controller drives all flash pins.
- Write cycle: 2 phi2 cycles.
  - SETUP: rom_a/rom_d_out valid, rom_ce_n 0, rom_d_oe 1, rom_we_n 1.
  - STROBE: same, rom_we_n 0.
  - The next cycle may start immediately.
- FSM: IDLE -> W1(A1/AA) -> W2(A2/55) -> W3, then:
  - Program: W3(A1/A0) -> W4(ADDR/DATA) -> POLL.
  - Erase: W3(A1/80) -> W4(A1/AA) -> W5(A2/55) -> W6, then POLL.
    - Sector erase W6: {ADDR[18:16],16'h0}/30.
    - Chip erase W6: A1/10.
- busy asserts the cycle after an accepted CMD and stays set through DONE.
- POLL: rom_ce_n 0, rom_oe_n 0, rom_d_oe 0, rom_a = target address. Sample rom_d_in every cycle; the timeout counter increments.
  - Complete when DQ7 == expected (program: DATA[7]; erase: 1).
  - If DQ5 = 1 and DQ7 still mismatched on the following sample -> FAIL.
  - If the counter reaches PROG_TMO or ERASE_TMO -> FAIL.
- FAIL: set tmo_err, issue write cycle (any address)/F0, then go to IDLE.
- DONE: one cycle; busy deasserts; go to IDLE.
- Abort (F0) in any non-IDLE state: finish the current write cycle, issue a reset write cycle, go to IDLE. tmo_err is not set.
- reset_n low mid-operation: immediate return to reset values; no reset cycle is issued to flash.
- ADDR does not auto-increment.

Optional Feature:
- Macro: FLASH_PROG_VERIFY_EN.
- Defined: after a program completes, a VERIFY state does 1 read cycle at ADDR. If rom_d_in != DATA, set vfy_err; then DONE. Program latency grows by 1 cycle.
- Undefined: no VERIFY state; vfy_err is tied 0.

Decomposition:
- Package flash_pkg holds:
  - FSM state enum.
  - Register offsets (OFS_ADDR0..OFS_KEY).
  - Command codes CMD_PROG/CMD_SERASE/CMD_CERASE/CMD_ABORT.
  - KEY_VALUE 8'h5A.
  - JEDEC bytes AA/55/A0/80/30/10/F0.
- Sub-module flash_wr_cycle: takes start/addr/data, produces the 2-phase SETUP/STROBE pin sequence and a done pulse.

Test Plan:
- ADDR=$2C123, DATA=$A5, KEY=$5A, CMD=$01 -> write sequence 555/AA, 2AA/55, 555/A0, 2C123/A5. POLL ends when the model returns DQ7=1. STATUS=$00 after DONE.
- CMD=$01 without KEY -> no rom_we_n strobe, busy stays 0. STATUS read = $00.
- KEY, ADDR[18:16]=3'b101, CMD=$02 -> 6 write cycles ending 50000/30. busy stays 1 until the model releases DQ7=1.
- Program with the model holding DQ7 wrong and DQ5=1 -> FAIL; F0 reset cycle issued; STATUS=$40.
- Chip erase, then CMD=$F0 during W4 -> W4 completes, F0 cycle issued, IDLE, STATUS=$00. reset_n low during POLL -> all outputs at reset values on the next edge.
- FLASH_PROG_VERIFY_EN: model reads back $A4 for DATA=$A5 -> STATUS=$20.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared types and constants for the cartridge flash programming sequencer.
// Combinational definitions only; no latency, no flow control.
// FSM states, CCTL register offsets, command codes and JEDEC command bytes.
package flash_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W1,
        S_W2,
        S_W3,
        S_W4,
        S_W5,
        S_W6,
        S_POLL,
        S_VERIFY,
        S_FAIL,
        S_ABORT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_PROG,
        OP_SERASE,
        OP_CERASE
    } op_t;

    localparam logic [4:0] WIN_BASE = 5'b11010;

    localparam logic [2:0] OFS_ADDR0 = 3'd0;
    localparam logic [2:0] OFS_ADDR1 = 3'd1;
    localparam logic [2:0] OFS_ADDR2 = 3'd2;
    localparam logic [2:0] OFS_DATA  = 3'd3;
    localparam logic [2:0] OFS_CMD   = 3'd4;
    localparam logic [2:0] OFS_KEY   = 3'd5;

    localparam logic [7:0] CMD_PROG   = 8'h01;
    localparam logic [7:0] CMD_SERASE = 8'h02;
    localparam logic [7:0] CMD_CERASE = 8'h03;
    localparam logic [7:0] CMD_ABORT  = 8'hF0;

    localparam logic [7:0] KEY_VALUE = 8'h5A;

    localparam logic [7:0] JEDEC_AA = 8'hAA;
    localparam logic [7:0] JEDEC_55 = 8'h55;
    localparam logic [7:0] JEDEC_A0 = 8'hA0;
    localparam logic [7:0] JEDEC_80 = 8'h80;
    localparam logic [7:0] JEDEC_30 = 8'h30;
    localparam logic [7:0] JEDEC_10 = 8'h10;
    localparam logic [7:0] JEDEC_F0 = 8'hF0;

    function automatic logic is_cmd_wr(input state_t s);
        return (s == S_W1) || (s == S_W2) || (s == S_W3) ||
               (s == S_W4) || (s == S_W5) || (s == S_W6);
    endfunction

    function automatic logic is_wr_state(input state_t s);
        return is_cmd_wr(s) || (s == S_FAIL) || (s == S_ABORT);
    endfunction

endpackage

// File: rtl/flash_prog_ctrl_if.sv
// Atari cartridge-port and flash-pin bundle for the flash programming sequencer.
// Wires only; no latency, no flow control.
// master = sequencer side, slave = system/bench side.
interface flash_prog_ctrl_if;
    logic        cctl_n;
    logic        r_w;
    logic [7:0]  cart_a;
    logic [7:0]  cart_d_in;
    logic [7:0]  cart_d_out;
    logic        cart_d_oe;
    logic [18:0] map_rom_a;
    logic        map_ce_n;
    logic        map_oe_n;
    logic [18:0] rom_a;
    logic [7:0]  rom_d_in;
    logic [7:0]  rom_d_out;
    logic        rom_d_oe;
    logic        rom_ce_n;
    logic        rom_oe_n;
    logic        rom_we_n;
    logic        busy;

    modport master (
        input  cctl_n, r_w, cart_a, cart_d_in, map_rom_a, map_ce_n, map_oe_n, rom_d_in,
        output cart_d_out, cart_d_oe, rom_a, rom_d_out, rom_d_oe, rom_ce_n, rom_oe_n,
        output rom_we_n, busy
    );

    modport slave (
        output cctl_n, r_w, cart_a, cart_d_in, map_rom_a, map_ce_n, map_oe_n, rom_d_in,
        input  cart_d_out, cart_d_oe, rom_a, rom_d_out, rom_d_oe, rom_ce_n, rom_oe_n,
        input  rom_we_n, busy
    );
endinterface

// File: rtl/flash_wr_cycle.sv
// One flash write cycle: SETUP (we_n high) then STROBE (we_n low), done during STROBE.
// Latency: 2 cycles per write; a new cycle may begin on the cycle after done.
// No backpressure: start is held by the caller for the whole cycle.
module flash_wr_cycle (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [18:0] addr,
    input  logic [7:0]  data,
    output logic [18:0] wr_a,
    output logic [7:0]  wr_d,
    output logic        we_n,
    output logic        done
);
    logic strobe;

    // Toggles only while start is held, so back-to-back writes re-enter SETUP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            strobe <= 1'b0;
        end else begin
            strobe <= start & ~strobe;
        end
    end

    assign wr_a = addr;
    assign wr_d = data;
    assign we_n = ~strobe;
    assign done = strobe;
endmodule

// File: rtl/flash_prog_ctrl.sv
// 29F040 in-system programming sequencer behind CCTL $D5D0..$D5D7; FLASH_PROG_VERIFY_EN adds read-back verify.
// Latency: busy the cycle after an accepted CMD; 2 cycles per JEDEC write, then DQ7/DQ5 polling.
// No backpressure: register writes while busy are dropped, mapper is locked off the flash while busy.
module flash_prog_ctrl
    import flash_pkg::*;
#(
    parameter logic [18:0] UNLOCK_A1 = 19'h00555,
    parameter logic [18:0] UNLOCK_A2 = 19'h002AA,
    parameter int          TMO_W     = 27,
    parameter logic [TMO_W-1:0] PROG_TMO  = 27'd1024,
    parameter logic [TMO_W-1:0] ERASE_TMO = 27'd113000000
) (
    input  logic phi2,
    input  logic reset_n,
    flash_prog_ctrl_if.master bus
);
    state_t state, state_n;
    op_t    op;

    logic [18:0]      addr_r;
    logic [7:0]       data_r;
    logic             armed;
    logic             tmo_err;
    logic             vfy_err;
    logic             abort_pend;
    logic             dq5_seen;
    logic [TMO_W-1:0] tmo_cnt;

    logic        hit, reg_wr, cmd_wr, start_cmd, accept, abort_wr, abort_req;
    logic [2:0]  ofs;
    logic [7:0]  status;
    logic [18:0] poll_a;
    logic        dq7_ok, tmo_hit;
    logic [TMO_W-1:0] tmo_lim;

    logic        wr_start, wr_we_n, wr_done;
    logic [18:0] wr_addr, wr_a;
    logic [7:0]  wr_data, wr_d;

    assign hit       = ~bus.cctl_n & (bus.cart_a[7:3] == WIN_BASE);
    assign ofs       = bus.cart_a[2:0];
    assign reg_wr    = hit & ~bus.r_w;
    assign cmd_wr    = reg_wr & (ofs == OFS_CMD);
    assign start_cmd = (bus.cart_d_in == CMD_PROG) || (bus.cart_d_in == CMD_SERASE) ||
                       (bus.cart_d_in == CMD_CERASE);
    assign accept    = cmd_wr & start_cmd & armed & (state == S_IDLE);
    assign abort_wr  = cmd_wr & (bus.cart_d_in == CMD_ABORT) & (state != S_IDLE);
    assign abort_req = abort_pend | abort_wr;

    assign status         = {bus.busy, tmo_err, vfy_err, 4'b0000, armed};
    assign bus.cart_d_out = (ofs == OFS_CMD) ? status : 8'h00;
    assign bus.cart_d_oe  = hit & bus.r_w & phi2;
    assign bus.busy       = (state != S_IDLE);

    assign poll_a  = (op == OP_SERASE) ? {addr_r[18:16], 16'h0000} : addr_r;
    assign dq7_ok  = bus.rom_d_in[7] == ((op == OP_PROG) ? data_r[7] : 1'b1);
    assign tmo_lim = (op == OP_PROG) ? PROG_TMO : ERASE_TMO;
    assign tmo_hit = (tmo_cnt + TMO_W'(1)) >= tmo_lim;

    flash_wr_cycle u_wr (
        .clk   (phi2),
        .rst_n (reset_n),
        .start (wr_start),
        .addr  (wr_addr),
        .data  (wr_data),
        .wr_a  (wr_a),
        .wr_d  (wr_d),
        .we_n  (wr_we_n),
        .done  (wr_done)
    );

    always_ff @(posedge phi2) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        wr_start = is_wr_state(state);
        wr_addr  = UNLOCK_A1;
        wr_data  = JEDEC_F0;
        case (state)
            S_IDLE: if (accept) state_n = S_W1;
            S_W1: begin
                wr_data = JEDEC_AA;
                if (wr_done) state_n = S_W2;
            end
            S_W2: begin
                wr_addr = UNLOCK_A2;
                wr_data = JEDEC_55;
                if (wr_done) state_n = S_W3;
            end
            S_W3: begin
                wr_data = (op == OP_PROG) ? JEDEC_A0 : JEDEC_80;
                if (wr_done) state_n = S_W4;
            end
            S_W4: begin
                if (op == OP_PROG) begin
                    wr_addr = addr_r;
                    wr_data = data_r;
                    if (wr_done) state_n = S_POLL;
                end else begin
                    wr_data = JEDEC_AA;
                    if (wr_done) state_n = S_W5;
                end
            end
            S_W5: begin
                wr_addr = UNLOCK_A2;
                wr_data = JEDEC_55;
                if (wr_done) state_n = S_W6;
            end
            S_W6: begin
                if (op == OP_SERASE) begin
                    wr_addr = {addr_r[18:16], 16'h0000};
                    wr_data = JEDEC_30;
                end else begin
                    wr_data = JEDEC_10;
                end
                if (wr_done) state_n = S_POLL;
            end
            S_POLL: begin
                // DQ5 only counts as failure if the next sample still mismatches on DQ7.
                if (dq7_ok) begin
`ifdef FLASH_PROG_VERIFY_EN
                    state_n = (op == OP_PROG) ? S_VERIFY : S_DONE;
`else
                    state_n = S_DONE;
`endif
                end else if (abort_req) begin
                    state_n = S_ABORT;
                end else if (dq5_seen || tmo_hit) begin
                    state_n = S_FAIL;
                end
            end
`ifdef FLASH_PROG_VERIFY_EN
            S_VERIFY: state_n = S_DONE;
`endif
            S_FAIL, S_ABORT: if (wr_done) state_n = S_IDLE;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        // An abort lets the in-flight command write finish before the reset write.
        if (is_cmd_wr(state) && wr_done && abort_req) state_n = S_ABORT;
    end

    always_ff @(posedge phi2) begin
        if (!reset_n) begin
            addr_r     <= '0;
            data_r     <= '0;
            armed      <= 1'b0;
            tmo_err    <= 1'b0;
            abort_pend <= 1'b0;
            dq5_seen   <= 1'b0;
            tmo_cnt    <= '0;
            op         <= OP_PROG;
        end else begin
            if (reg_wr && state == S_IDLE) begin
                case (ofs)
                    OFS_ADDR0: addr_r[7:0]   <= bus.cart_d_in;
                    OFS_ADDR1: addr_r[15:8]  <= bus.cart_d_in;
                    OFS_ADDR2: addr_r[18:16] <= bus.cart_d_in[2:0];
                    OFS_DATA:  data_r        <= bus.cart_d_in;
                    default: ;
                endcase
            end
            if (reg_wr && ofs == OFS_KEY) armed <= (bus.cart_d_in == KEY_VALUE);
            if (accept) begin
                armed   <= 1'b0;
                tmo_err <= 1'b0;
                case (bus.cart_d_in)
                    CMD_SERASE: op <= OP_SERASE;
                    CMD_CERASE: op <= OP_CERASE;
                    default:    op <= OP_PROG;
                endcase
            end
            if (state == S_FAIL) tmo_err <= 1'b1;
            if (state == S_IDLE || state == S_ABORT || state == S_FAIL || state == S_DONE) begin
                abort_pend <= 1'b0;
            end else if (abort_wr) begin
                abort_pend <= 1'b1;
            end
            dq5_seen <= (state == S_POLL) & bus.rom_d_in[5] & ~dq7_ok;
            tmo_cnt  <= (state == S_POLL) ? tmo_cnt + TMO_W'(1) : '0;
        end
    end

`ifdef FLASH_PROG_VERIFY_EN
    always_ff @(posedge phi2) begin
        if (!reset_n) begin
            vfy_err <= 1'b0;
        end else if (accept) begin
            vfy_err <= 1'b0;
        end else if (state == S_VERIFY && bus.rom_d_in != data_r) begin
            vfy_err <= 1'b1;
        end
    end
`else
    logic unused_rd;
    assign vfy_err   = 1'b0;
    assign unused_rd = ^{bus.rom_d_in[6], bus.rom_d_in[4:0]};
`endif

    always_comb begin
        bus.rom_a     = bus.map_rom_a;
        bus.rom_ce_n  = bus.map_ce_n;
        bus.rom_oe_n  = bus.map_oe_n;
        bus.rom_we_n  = 1'b1;
        bus.rom_d_oe  = 1'b0;
        bus.rom_d_out = 8'h00;
        if (wr_start) begin
            bus.rom_a     = wr_a;
            bus.rom_d_out = wr_d;
            bus.rom_ce_n  = 1'b0;
            bus.rom_oe_n  = 1'b1;
            bus.rom_we_n  = wr_we_n;
            bus.rom_d_oe  = 1'b1;
        end else if (state == S_POLL || state == S_VERIFY) begin
            bus.rom_a    = poll_a;
            bus.rom_ce_n = 1'b0;
            bus.rom_oe_n = 1'b0;
        end else if (state != S_IDLE) begin
            bus.rom_a    = addr_r;
            bus.rom_ce_n = 1'b1;
            bus.rom_oe_n = 1'b1;
        end
    end
endmodule

// File: tb/tb_flash_prog_ctrl.sv
// Directed bench for flash_prog_ctrl: register-access vector table plus program/erase/fail/abort/reset sequences.
// Flash strobes are captured on the falling edge and compared against hand-written JEDEC sequences.
module tb_flash_prog_ctrl;
    import flash_pkg::*;

    logic phi2 = 1'b0;
    logic reset_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;
    logic [26:0] wq[$];

    flash_prog_ctrl_if bus_if ();

    flash_prog_ctrl dut (
        .phi2    (phi2),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 phi2 = ~phi2;

    always @(negedge phi2) begin
        if (reset_n && !bus_if.rom_we_n) wq.push_back({bus_if.rom_a, bus_if.rom_d_out});
    end

    typedef struct {
        logic       is_wr;
        logic [2:0] ofs;
        logic [7:0] dat;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] ofs, input logic [7:0] d);
        @(negedge phi2);
        bus_if.cctl_n    = 1'b0;
        bus_if.r_w       = 1'b0;
        bus_if.cart_a    = {5'b11010, ofs};
        bus_if.cart_d_in = d;
        @(negedge phi2);
        bus_if.cctl_n = 1'b1;
        bus_if.r_w    = 1'b1;
        bus_if.cart_a = 8'h00;
    endtask

    task automatic bus_rd(input logic [2:0] ofs, output logic [7:0] d, output logic oe);
        @(negedge phi2);
        bus_if.cctl_n = 1'b0;
        bus_if.r_w    = 1'b1;
        bus_if.cart_a = {5'b11010, ofs};
        @(posedge phi2);
        #1;
        d  = bus_if.cart_d_out;
        oe = bus_if.cart_d_oe;
        @(negedge phi2);
        bus_if.cctl_n = 1'b1;
        bus_if.cart_a = 8'h00;
    endtask

    task automatic check_status(input string nm, input logic [7:0] exp);
        logic [7:0] d;
        logic oe;
        bus_rd(OFS_CMD, d, oe);
        check(nm, 32'(d), 32'(exp));
    endtask

    task automatic wait_strobes(input int n, input int budget, input string nm);
        int k = 0;
        while (wq.size() < n && k < budget) begin
            @(posedge phi2);
            k++;
        end
        check(nm, 32'(wq.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int k = 0;
        do begin
            @(posedge phi2);
            #1;
            k++;
        end while (bus_if.busy && k < budget);
        check(nm, 32'(bus_if.busy), 32'd0);
    endtask

    task automatic check_wr(input int i, input logic [18:0] a, input logic [7:0] d, input string nm);
        logic [26:0] got;
        got = (i < wq.size()) ? wq[i] : 27'h7FFFFFF;
        check(nm, 32'(got), 32'({a, d}));
    endtask

    task automatic start_cmd(input logic [18:0] a, input logic [7:0] d, input logic [7:0] cmd);
        bus_wr(OFS_ADDR0, a[7:0]);
        bus_wr(OFS_ADDR1, a[15:8]);
        bus_wr(OFS_ADDR2, {5'b00000, a[18:16]});
        bus_wr(OFS_DATA, d);
        bus_wr(OFS_KEY, KEY_VALUE);
        wq.delete();
        bus_wr(OFS_CMD, cmd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic       oe;
        logic [7:0] vfy_exp;

        bus_if.cctl_n    = 1'b1;
        bus_if.r_w       = 1'b1;
        bus_if.cart_a    = 8'h00;
        bus_if.cart_d_in = 8'h00;
        bus_if.map_rom_a = 19'h12345;
        bus_if.map_ce_n  = 1'b1;
        bus_if.map_oe_n  = 1'b1;
        bus_if.rom_d_in  = 8'h00;

        vt[0]  = '{1'b0, OFS_CMD,   8'h00, 8'h00};
        vt[1]  = '{1'b1, OFS_KEY,   8'h33, 8'h00};
        vt[2]  = '{1'b1, OFS_CMD,   8'h01, 8'h00};
        vt[3]  = '{1'b0, OFS_CMD,   8'h00, 8'h00};
        vt[4]  = '{1'b1, OFS_KEY,   8'h5A, 8'h00};
        vt[5]  = '{1'b0, OFS_CMD,   8'h00, 8'h01};
        vt[6]  = '{1'b0, OFS_ADDR0, 8'h00, 8'h00};
        vt[7]  = '{1'b0, OFS_DATA,  8'h00, 8'h00};
        vt[8]  = '{1'b1, OFS_KEY,   8'h11, 8'h00};
        vt[9]  = '{1'b0, OFS_CMD,   8'h00, 8'h00};
        vt[10] = '{1'b1, OFS_CMD,   8'h02, 8'h00};
        vt[11] = '{1'b0, OFS_CMD,   8'h00, 8'h00};

        // Reset state and mapper pass-through.
        repeat (3) @(posedge phi2);
        #1;
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_we_n", 32'(bus_if.rom_we_n), 32'd1);
        check("rst_d_oe", 32'(bus_if.rom_d_oe), 32'd0);
        check("rst_rom_a", 32'(bus_if.rom_a), 32'h12345);
        @(negedge phi2);
        reset_n = 1'b1;

        // Register access table; unarmed CMD writes must not start anything.
        for (int i = 0; i < 12; i++) begin
            if (vt[i].is_wr) begin
                bus_wr(vt[i].ofs, vt[i].dat);
            end else begin
                bus_rd(vt[i].ofs, d, oe);
                check($sformatf("vec%0d_rd", i), 32'(d), 32'(vt[i].exp));
                check($sformatf("vec%0d_oe", i), 32'(oe), 32'd1);
            end
        end
        check("unarmed_no_strobe", 32'(wq.size()), 32'd0);
        check("unarmed_busy", 32'(bus_if.busy), 32'd0);

        // Reads outside the window or with phi2 low must not drive cart_d.
        @(negedge phi2);
        bus_if.cctl_n = 1'b0;
        bus_if.cart_a = 8'hE4;
        @(posedge phi2);
        #1;
        check("oe_outside_window", 32'(bus_if.cart_d_oe), 32'd0);
        bus_if.cart_a = 8'hD4;
        @(negedge phi2);
        #1;
        check("oe_phi2_low", 32'(bus_if.cart_d_oe), 32'd0);
        bus_if.cctl_n = 1'b1;
        bus_if.cart_a = 8'h00;

        // Byte program $2C123 <- $A5.
        bus_if.rom_d_in = 8'h00;
        start_cmd(19'h2C123, 8'hA5, CMD_PROG);
        check("prog_busy_rise", 32'(bus_if.busy), 32'd1);
        wait_strobes(4, 200, "prog_strobes");
        repeat (3) @(posedge phi2);
        #1;
        check("prog_poll_busy", 32'(bus_if.busy), 32'd1);
        check("prog_poll_a", 32'(bus_if.rom_a), 32'h2C123);
        check("prog_poll_oe_n", 32'(bus_if.rom_oe_n), 32'd0);
        check("prog_poll_d_oe", 32'(bus_if.rom_d_oe), 32'd0);
        bus_if.rom_d_in = 8'hA5;
        wait_idle(50, "prog_idle");
        check_wr(0, 19'h00555, 8'hAA, "prog_w1");
        check_wr(1, 19'h002AA, 8'h55, "prog_w2");
        check_wr(2, 19'h00555, 8'hA0, "prog_w3");
        check_wr(3, 19'h2C123, 8'hA5, "prog_w4");
        check("prog_count", 32'(wq.size()), 32'd4);
        check_status("prog_status", 8'h00);

        // Sector erase of sector 5; ADDR writes while busy are ignored.
        bus_if.rom_d_in = 8'h00;
        start_cmd(19'h52345, 8'h00, CMD_SERASE);
        wait_strobes(6, 200, "serase_strobes");
        bus_wr(OFS_ADDR2, 8'h00);
        check_status("serase_status_busy", 8'h80);
        #1;
        check("serase_poll_a", 32'(bus_if.rom_a), 32'h50000);
        bus_if.rom_d_in = 8'h80;
        wait_idle(50, "serase_idle");
        check_wr(2, 19'h00555, 8'h80, "serase_w3");
        check_wr(3, 19'h00555, 8'hAA, "serase_w4");
        check_wr(4, 19'h002AA, 8'h55, "serase_w5");
        check_wr(5, 19'h50000, 8'h30, "serase_w6");
        check_status("serase_status", 8'h00);

        // Program with DQ5 set and DQ7 wrong: fail, reset write, tmo_err.
        bus_if.rom_d_in = 8'h20;
        start_cmd(19'h2C123, 8'hA5, CMD_PROG);
        wait_strobes(5, 200, "dq5_strobes");
        wait_idle(50, "dq5_idle");
        check("dq5_f0", 32'((wq.size() > 4) ? wq[4][7:0] : 8'h00), 32'hF0);
        check("dq5_count", 32'(wq.size()), 32'd5);
        check_status("dq5_status", 8'h40);

        // Program that never completes: times out after the programming budget.
        bus_if.rom_d_in = 8'h00;
        start_cmd(19'h2C123, 8'hA5, CMD_PROG);
        wait_strobes(4, 200, "tmo_strobes");
        check_status("tmo_status_busy", 8'h80);
        repeat (900) @(posedge phi2);
        #1;
        check("tmo_not_early", 32'(bus_if.busy), 32'd1);
        wait_strobes(5, 400, "tmo_f0_strobe");
        wait_idle(50, "tmo_idle");
        check("tmo_f0", 32'((wq.size() > 4) ? wq[4][7:0] : 8'h00), 32'hF0);
        check_status("tmo_status", 8'h40);

        // Chip erase aborted during W4.
        start_cmd(19'h00000, 8'h00, CMD_CERASE);
        wait_strobes(3, 200, "abort_w3");
        bus_wr(OFS_CMD, CMD_ABORT);
        wait_idle(50, "abort_idle");
        check_wr(3, 19'h00555, 8'hAA, "abort_w4_done");
        check("abort_f0", 32'((wq.size() > 4) ? wq[4][7:0] : 8'h00), 32'hF0);
        check("abort_count", 32'(wq.size()), 32'd5);
        check_status("abort_status", 8'h00);

        // reset_n mid-POLL: back to reset values, no reset write to flash.
        bus_if.rom_d_in = 8'h00;
        start_cmd(19'h2C123, 8'hA5, CMD_PROG);
        wait_strobes(4, 200, "rstpoll_strobes");
        repeat (2) @(posedge phi2);
        @(negedge phi2);
        reset_n = 1'b0;
        bus_if.map_rom_a = 19'h0ABCD;
        @(posedge phi2);
        #1;
        check("rstpoll_busy", 32'(bus_if.busy), 32'd0);
        check("rstpoll_we_n", 32'(bus_if.rom_we_n), 32'd1);
        check("rstpoll_d_oe", 32'(bus_if.rom_d_oe), 32'd0);
        check("rstpoll_oe_n", 32'(bus_if.rom_oe_n), 32'd1);
        check("rstpoll_rom_a", 32'(bus_if.rom_a), 32'h0ABCD);
        repeat (3) @(posedge phi2);
        @(negedge phi2);
        reset_n = 1'b1;
        repeat (4) @(posedge phi2);
        check("rstpoll_no_f0", 32'(wq.size()), 32'd4);
        check_status("rstpoll_status", 8'h00);

        // Read-back of $A4 for DATA $A5 (DQ7 matches, low bit differs).
`ifdef FLASH_PROG_VERIFY_EN
        vfy_exp = 8'h20;
`else
        vfy_exp = 8'h00;
`endif
        bus_if.rom_d_in = 8'hA4;
        start_cmd(19'h2C123, 8'hA5, CMD_PROG);
        wait_strobes(4, 200, "vfy_strobes");
        wait_idle(50, "vfy_idle");
        check_status("vfy_status", vfy_exp);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
